ledwalk_ctrl: RTL and testbench

- Controller that sequences the 9-LED walker bank on request.
- Accepts a one-cycle walk request with direction and mode, then steps a single lit LED across the bank at a programmable rate.
- Signals completion, and supports abort mid-walk.
- Sits between board-level request sources (button debouncer, command decoder) and the LED pins; replaces a free-running walker where start/stop control is needed.

---
 rtl/ledwalk_ctrl_pkg.sv | 18 +
 rtl/ledwalk_ctrl_if.sv | 26 ++
 rtl/ledwalk_ctrl_step_timer.sv | 29 ++
 rtl/ledwalk_ctrl.sv | 156 +++++++++++++++
 tb/tb_ledwalk_ctrl.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ledwalk_ctrl_pkg.sv
// ledwalk_pkg: shared types and constants for the LED walker controller.
package ledwalk_pkg;

    // Default LED bank width.
    localparam int unsigned NLEDS_DEFAULT = 9;

    // Start-direction encoding of the request's dir bit.
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Walker FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2
    } state_t;

endpackage

// File: rtl/ledwalk_ctrl_if.sv
// ledwalk_ctrl_if: request / status bundle between a request source and the walker.
interface ledwalk_ctrl_if
    import ledwalk_pkg::*;
#(
    parameter int unsigned NLEDS = NLEDS_DEFAULT
);
    logic             i_req;
    logic             i_dir;
    logic             i_bounce;
    logic             i_abort;
    logic [NLEDS-1:0] o_led;
    logic             o_busy;
    logic             o_done;

    // Request source side.
    modport master (
        output i_req, i_dir, i_bounce, i_abort,
        input  o_led, o_busy, o_done
    );

    // Walker controller side.
    modport slave (
        input  i_req, i_dir, i_bounce, i_abort,
        output o_led, o_busy, o_done
    );
endinterface

// File: rtl/ledwalk_ctrl_step_timer.sv
// ledwalk_step_timer: loadable, self-reloading down-counter that marks the
// last cycle of each STEP_CYCLES-long LED position.
module ledwalk_step_timer #(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_stb
);
    localparam int unsigned CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Count down while enabled, wrapping back to the reload value after zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= RELOAD;
        end else if (i_en) begin
            cnt_q <= (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    assign o_stb = (cnt_q == '0);
endmodule

// File: rtl/ledwalk_ctrl.sv
// ledwalk_ctrl: on request, walks a single lit LED across an NLEDS-wide bank,
// one position every STEP_CYCLES clocks, single pass or there-and-back.
// Optional macro LEDWALK_CTRL_HEARTBEAT_EN: 1 Hz blink on o_led[0] while idle.
module ledwalk_ctrl
    import ledwalk_pkg::*;
#(
    parameter int unsigned CLK_RATE_HZ = 12_000_000,
    parameter int unsigned STEP_CYCLES = 1_200_000,
    parameter int unsigned NLEDS       = NLEDS_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_reset,
    ledwalk_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [NLEDS-1:0] led_q, led_d;
    logic             done_q, done_d;
    logic             dir_q, bounce_q;
    logic             accept, step, tmr_stb;
    logic             at_far, at_start;
    logic [NLEDS-1:0] led_fwd, led_back;

    assign accept = (state_q == IDLE) && bus.i_req && !bus.i_abort;
    assign step   = (state_q != IDLE) && tmr_stb;

    // Positions relative to the latched start direction.
    assign at_far   = (dir_q == DIR_UP) ? led_q[NLEDS-1] : led_q[0];
    assign at_start = (dir_q == DIR_UP) ? led_q[0] : led_q[NLEDS-1];
    assign led_fwd  = (dir_q == DIR_UP) ? (led_q << 1) : (led_q >> 1);
    assign led_back = (dir_q == DIR_UP) ? (led_q >> 1) : (led_q << 1);

    ledwalk_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (accept),
        .i_en    (state_q != IDLE),
        .o_stb   (tmr_stb)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = FWD;
            FWD:  if (step && at_far) state_d = bounce_q ? REV : IDLE;
            REV:  if (step && at_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.i_abort) begin
            state_d = IDLE;
        end
    end

    // Next LED pattern and completion pulse for the output registers.
    always_comb begin
        led_d  = led_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                led_d = '0;
                if (accept) begin
                    led_d = (bus.i_dir == DIR_DN) ? NLEDS'(1) << (NLEDS - 1) : NLEDS'(1);
                end
            end
            FWD: begin
                if (step) begin
                    if (!at_far) begin
                        led_d = led_fwd;
                    end else if (bounce_q) begin
                        led_d = led_back;
                    end else begin
                        led_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end
            REV: begin
                if (step) begin
                    if (at_start) begin
                        led_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        led_d = led_back;
                    end
                end
            end
            default: led_d = '0;
        endcase
        if (bus.i_abort) begin
            led_d  = '0;
            done_d = 1'b0;
        end
    end

    // Output registers plus direction/mode captured at accept.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            led_q    <= '0;
            done_q   <= 1'b0;
            dir_q    <= DIR_UP;
            bounce_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            done_q <= done_d;
            if (accept) begin
                dir_q    <= bus.i_dir;
                bounce_q <= bus.i_bounce;
            end
        end
    end

    assign bus.o_busy = (state_q != IDLE);
    assign bus.o_done = done_q;

`ifdef LEDWALK_CTRL_HEARTBEAT_EN
    localparam int unsigned HB_HALF = (CLK_RATE_HZ / 2 > 1) ? CLK_RATE_HZ / 2 : 1;
    localparam int unsigned HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF - 1);

    logic [HB_W-1:0] hb_cnt_q;
    logic            hb_q;

    // Free-running half-period counter toggling the heartbeat level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else if (hb_cnt_q == HB_LAST) begin
            hb_cnt_q <= '0;
            hb_q     <= !hb_q;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
        end
    end

    // led_q is all-zero in IDLE, so OR-ing in the blink cannot disturb a walk.
    assign bus.o_led = led_q | NLEDS'(hb_q && (state_q == IDLE));
`else
    // Keeps the clock-rate parameter referenced when no heartbeat is built.
    logic unused_clk_rate;
    assign unused_clk_rate = ^CLK_RATE_HZ;

    assign bus.o_led = led_q;
`endif
endmodule

// File: tb/tb_ledwalk_ctrl.sv
// tb_ledwalk_ctrl: directed plus randomized stimulus against a cycle-level
// walk model (elapsed-time arithmetic, not a state machine).
`timescale 1ns/1ps
module tb_ledwalk_ctrl;
    localparam int unsigned N = 9;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ledwalk_ctrl_if #(.NLEDS(N)) bus();

    ledwalk_ctrl #(
        .CLK_RATE_HZ (12_000_000),
        .STEP_CYCLES (S),
        .NLEDS       (N)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: whether a walk is running, how many cycles it has shown.
    bit          m_busy   = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_dir    = 1'b0;
    bit          m_bounce = 1'b0;
    int unsigned m_age    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned walk_len(input bit bounce);
        return bounce ? (2 * N - 1) * S : N * S;
    endfunction

    // Position k along the path; bounce paths fold back after the far end.
    function automatic logic [N-1:0] exp_led();
        int unsigned k;
        int unsigned idx;
        logic [N-1:0] one;
        if (!m_busy) return '0;
        k = (m_age - 1) / S;
        if (m_bounce && k >= N) k = 2 * N - 2 - k;
        idx = m_dir ? (N - 1 - k) : k;
        one = 1;
        return one << idx;
    endfunction

    task automatic model_step(input bit rst, input bit req, input bit dir, input bit bnc, input bit abt);
        if (rst || abt) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (m_busy) begin
            if (m_age == walk_len(m_bounce)) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_age++;
                m_done = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (req) begin
                m_busy   = 1'b1;
                m_age    = 1;
                m_dir    = dir;
                m_bounce = bnc;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then sample after the edge.
    task automatic cycle(input bit rst, input bit req, input bit dir, input bit bnc,
                         input bit abt, input string tag);
        reset        = rst;
        bus.i_req    = req;
        bus.i_dir    = dir;
        bus.i_bounce = bnc;
        bus.i_abort  = abt;
        model_step(rst, req, dir, bnc, abt);
        @(posedge clk);
        #1;
        check({tag, ".led"},  32'(bus.o_led),  32'(exp_led()));
        check({tag, ".busy"}, 32'(bus.o_busy), 32'(m_busy));
        check({tag, ".done"}, 32'(bus.o_done), 32'(m_done));
    endtask

    task automatic idle(input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        bus.i_req    = 1'b0;
        bus.i_dir    = 1'b0;
        bus.i_bounce = 1'b0;
        bus.i_abort  = 1'b0;

        // Reset held with a pending request: nothing is accepted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
        idle(2, "post_reset");

        // Single pass up.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "up");
        idle(40, "up");

        // Bounce starting at the top.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "bounce_dn");
        idle(72, "bounce_dn");

        // Request while busy is ignored.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "busy_req");
        idle(9, "busy_req");
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "busy_req");
        idle(32, "busy_req");

        // Abort mid-walk.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "abort");
        idle(13, "abort");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "abort");
        idle(30, "abort");

        // Abort together with a request in IDLE: no start.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "abort_req");
        idle(5, "abort_req");

        // Request held high: re-accept on the completion cycle.
        for (int i = 0; i < 80; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "b2b");
        idle(40, "b2b");

        // Randomized traffic including occasional abort and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 999) == 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 79) == 0),
                  "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
